ann_face_collector: RTL and testbench

Consumes the per-window decision stream from the ANN threshold stage and turns it into a list of detected face windows. It tags each decision with its raster window coordinate and buffers face candidates in a small FIFO. It presents them to the downstream box-drawing/readout logic over a valid/ack handshake. It also reports per-frame candidate count, overflow and end-of-frame.

---
 rtl/ann_pkg.sv | 27 ++
 rtl/ann_sync_fifo.sv | 46 ++++
 rtl/ann_face_collector.sv | 147 ++++++++++++++
 tb/tb_ann_face_collector.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared definitions for the ANN face collector: scan geometry defaults,
// coordinate widths, score constants and the candidate entry record.
package ann_pkg;

   localparam int X_POS_DEF = 300;
   localparam int Y_POS_DEF = 220;
   localparam int X_W       = 9;
   localparam int Y_W       = 8;
   localparam int SCORE_W   = 32;

   // Q8.24 logsig constants shared with the threshold stage.
   localparam logic [SCORE_W-1:0] THRESHOLD    = 32'h0080_0000;
   localparam logic [SCORE_W-1:0] REJECT_SCORE = 32'h0011_EB85;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [SCORE_W-1:0] score;
   } ann_entry_t;

   localparam int ENTRY_W = $bits(ann_entry_t);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ann_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted
// when a pop happens in the same cycle.
module ann_sync_fifo #(
   parameter int WIDTH = 49,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ann_face_collector.sv
// Tags ANN window decisions with raster coordinates, queues face candidates
// and reports per-frame count, overflow and end-of-frame.
module ann_face_collector
   import ann_pkg::*;
#(
   parameter int X_POS      = X_POS_DEF,
   parameter int Y_POS      = Y_POS_DEF,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 8
) (
   input  logic               iClk,
   input  logic               iReset_n,
   input  logic               iFrame_start,
   input  logic               iInput_ready,
   input  logic               iFlag,
   input  logic [31:0]        iData_in,
   output logic               oValid,
   input  logic               iAck,
   output logic [8:0]         oX,
   output logic [7:0]         oY,
   output logic [31:0]        oScore,
   output logic [CNT_W-1:0]   oFace_count,
   output logic               oOverflow,
   output logic               oFrame_done
);

   localparam logic [X_W-1:0] X_LAST = X_W'(X_POS - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_POS - 1);

   logic [1:0]       state;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [X_W-1:0]   cur_x;
   logic [Y_W-1:0]   cur_y;
   logic             accept;
   logic             is_last;

   logic             s1_face;
   logic             s1_last;
   ann_entry_t       s1_entry;

   ann_entry_t       head;
   logic             full;
   logic             empty;
   logic             pop;
   logic             drop;
   logic [CNT_W-1:0] face_count;
   logic             overflow;
   logic             frame_done;

   // A frame start in the same cycle as a decision makes it window (0,0).
   always_comb begin
      cur_x   = iFrame_start ? '0 : x;
      cur_y   = iFrame_start ? '0 : y;
      accept  = iInput_ready & (iFrame_start | (state == ST_SCAN));
      is_last = (cur_x == X_LAST) && (cur_y == Y_LAST);
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state <= ST_IDLE;
      end else if (accept && is_last) begin
         state <= ST_DONE;
      end else if (iFrame_start) begin
         state <= ST_SCAN;
      end
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         x <= '0;
         y <= '0;
      end else if (accept) begin
         if (cur_x == X_LAST) begin
            x <= '0;
            y <= cur_y + 1'b1;
         end else begin
            x <= cur_x + 1'b1;
            y <= cur_y;
         end
      end else if (iFrame_start) begin
         x <= '0;
         y <= '0;
      end
   end

   // Decision register stage; the FIFO write happens one edge later.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         s1_face  <= 1'b0;
         s1_last  <= 1'b0;
         s1_entry <= '0;
      end else begin
         s1_face  <= accept & ~iFlag;
         s1_last  <= accept & is_last;
         if (accept) begin
            s1_entry.x     <= cur_x;
            s1_entry.y     <= cur_y;
            s1_entry.score <= iData_in;
         end
      end
   end

   ann_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (iClk),
      .rst_n (iReset_n),
      .push  (s1_face),
      .din   (s1_entry),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign pop  = iAck & ~empty;
   assign drop = s1_face & full & ~pop;

   // A new frame's clear wins over a stale candidate still in flight.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         face_count <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= s1_last;
         if (iFrame_start) begin
            face_count <= '0;
            overflow   <= 1'b0;
         end else begin
            if (s1_face && (face_count != {CNT_W{1'b1}})) face_count <= face_count + 1'b1;
            if (drop) overflow <= 1'b1;
         end
      end
   end

   assign oValid      = ~empty;
   assign oX          = oValid ? head.x : '0;
   assign oY          = oValid ? head.y : '0;
   assign oScore      = oValid ? head.score : '0;
   assign oFace_count = face_count;
   assign oOverflow   = overflow;
   assign oFrame_done = frame_done;

endmodule

// File: tb/tb_ann_face_collector.sv
// Directed self-checking bench for ann_face_collector on a 4x3 window grid
// with a 4-entry candidate FIFO.
module tb_ann_face_collector;

   logic        iClk = 1'b0;
   logic        iReset_n = 1'b1;
   logic        iFrame_start = 1'b0;
   logic        iInput_ready = 1'b0;
   logic        iFlag = 1'b1;
   logic [31:0] iData_in = '0;
   logic        iAck = 1'b0;
   logic        oValid;
   logic [8:0]  oX;
   logic [7:0]  oY;
   logic [31:0] oScore;
   logic [7:0]  oFace_count;
   logic        oOverflow;
   logic        oFrame_done;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;

   always #5 iClk = ~iClk;

   always @(posedge iClk) if (oFrame_done === 1'b1) done_cnt++;

   ann_face_collector #(
      .X_POS      (4),
      .Y_POS      (3),
      .FIFO_DEPTH (4),
      .CNT_W      (8)
   ) dut (
      .iClk         (iClk),
      .iReset_n     (iReset_n),
      .iFrame_start (iFrame_start),
      .iInput_ready (iInput_ready),
      .iFlag        (iFlag),
      .iData_in     (iData_in),
      .oValid       (oValid),
      .iAck         (iAck),
      .oX           (oX),
      .oY           (oY),
      .oScore       (oScore),
      .oFace_count  (oFace_count),
      .oOverflow    (oOverflow),
      .oFrame_done  (oFrame_done)
   );

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic start_frame();
      iFrame_start = 1'b1;
      tick();
      iFrame_start = 1'b0;
   endtask

   task automatic drive_window(input logic flag, input logic [31:0] score);
      iInput_ready = 1'b1;
      iFlag        = flag;
      iData_in     = score;
      tick();
      iInput_ready = 1'b0;
      iFlag        = 1'b1;
   endtask

   task automatic pop_head();
      iAck = 1'b1;
      tick();
      iAck = 1'b0;
   endtask

   task automatic test_reset();
      #2 iReset_n = 1'b0;
      #1;
      vectors++;
      if ({oValid, oX, oY, oScore} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_head: got valid=%0b x=%0d y=%0d score=%h, expected all zero", oValid, oX, oY, oScore);
      end
      vectors++;
      if ({oFace_count, oOverflow, oFrame_done} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_status: got count=%0d ovf=%0b done=%0b, expected 0 0 0", oFace_count, oOverflow, oFrame_done);
      end
      tick();
      tick();
      iReset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_frame();
      logic [8:0]  ex [2] = '{9'd1, 9'd2};
      logic [7:0]  ey [2] = '{8'd1, 8'd2};
      logic [31:0] es [2] = '{32'h00C0_0000, 32'h0090_0000};
      int done_before;
      done_before = done_cnt;
      start_frame();
      for (int w = 0; w < 12; w++) begin
         if (w == 5)       drive_window(1'b0, 32'h00C0_0000);
         else if (w == 10) drive_window(1'b0, 32'h0090_0000);
         else              drive_window(1'b1, 32'h0011_EB85);
      end
      vectors++;
      if (oFrame_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_done_early: got %0b expected 0", oFrame_done);
      end
      tick();
      vectors++;
      if (oFrame_done !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL basic_done_pulse: got %0b expected 1", oFrame_done);
      end
      tick();
      vectors++;
      if (oFrame_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_done_width: got %0b expected 0", oFrame_done);
      end
      tick();
      vectors++;
      if (done_cnt - done_before !== 1) begin
         miscompares++;
         $display("[TB] FAIL basic_done_count: got %0d pulses expected 1", done_cnt - done_before);
      end
      vectors++;
      if (oFace_count !== 8'd2 || oOverflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_count: got count=%0d ovf=%0b expected 2 0", oFace_count, oOverflow);
      end
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if ({oValid, oX, oY, oScore} !== {1'b1, ex[i], ey[i], es[i]}) begin
            miscompares++;
            $display("[TB] FAIL basic_entry%0d: got v=%0b (%0d,%0d,%h) expected (%0d,%0d,%h)", i, oValid, oX, oY, oScore, ex[i], ey[i], es[i]);
         end
         pop_head();
      end
      vectors++;
      if (oValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_drained: got valid=%0b expected 0", oValid);
      end
   endtask

   task automatic test_overflow();
      start_frame();
      for (int w = 0; w < 12; w++) drive_window(1'b0, 32'(w));
      tick();
      tick();
      vectors++;
      if (oFace_count !== 8'd12 || oOverflow !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ovf_status: got count=%0d ovf=%0b expected 12 1", oFace_count, oOverflow);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({oValid, oX, oY, oScore} !== {1'b1, 9'(i), 8'd0, 32'(i)}) begin
            miscompares++;
            $display("[TB] FAIL ovf_entry%0d: got v=%0b (%0d,%0d,%h) expected (%0d,0,%h)", i, oValid, oX, oY, oScore, i, i);
         end
         pop_head();
      end
      vectors++;
      if (oValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ovf_depth: got valid=%0b after 4 pops expected 0", oValid);
      end
   endtask

   task automatic test_full_with_ack();
      logic [8:0]  ex [4] = '{9'd1, 9'd2, 9'd3, 9'd0};
      logic [7:0]  ey [4] = '{8'd0, 8'd0, 8'd0, 8'd1};
      start_frame();
      for (int w = 0; w < 5; w++) drive_window(1'b0, 32'h10 + 32'(w));
      // Window 4's push lands on the next edge, together with this pop.
      iAck = 1'b1;
      tick();
      iAck = 1'b0;
      vectors++;
      if (oOverflow !== 1'b0 || oFace_count !== 8'd5) begin
         miscompares++;
         $display("[TB] FAIL fullack_status: got ovf=%0b count=%0d expected 0 5", oOverflow, oFace_count);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({oValid, oX, oY, oScore} !== {1'b1, ex[i], ey[i], 32'h11 + 32'(i)}) begin
            miscompares++;
            $display("[TB] FAIL fullack_entry%0d: got v=%0b (%0d,%0d,%h) expected (%0d,%0d,%h)", i, oValid, oX, oY, oScore, ex[i], ey[i], 32'h11 + 32'(i));
         end
         pop_head();
      end
      vectors++;
      if (oValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL fullack_occupancy: got valid=%0b after 4 pops expected 0", oValid);
      end
   endtask

   task automatic test_coincident_start();
      logic [8:0]  ex [3] = '{9'd2, 9'd3, 9'd0};
      logic [31:0] es [3] = '{32'h22, 32'h23, 32'h0000_BEEF};
      start_frame();
      for (int w = 0; w < 12; w++) drive_window(1'b0, 32'h20 + 32'(w));
      tick();
      tick();
      vectors++;
      if (oOverflow !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL coinc_pre_ovf: got %0b expected 1", oOverflow);
      end
      pop_head();
      pop_head();
      iFrame_start = 1'b1;
      drive_window(1'b0, 32'h0000_BEEF);
      iFrame_start = 1'b0;
      tick();
      vectors++;
      if (oFace_count !== 8'd1 || oOverflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL coinc_status: got count=%0d ovf=%0b expected 1 0", oFace_count, oOverflow);
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({oValid, oX, oY, oScore} !== {1'b1, ex[i], 8'd0, es[i]}) begin
            miscompares++;
            $display("[TB] FAIL coinc_entry%0d: got v=%0b (%0d,%0d,%h) expected (%0d,0,%h)", i, oValid, oX, oY, oScore, ex[i], es[i]);
         end
         pop_head();
      end
      vectors++;
      if (oValid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL coinc_drained: got valid=%0b expected 0", oValid);
      end
   endtask

   task automatic test_ignored_after_done();
      int done_before;
      start_frame();
      for (int w = 0; w < 12; w++) drive_window(1'b1, 32'h0011_EB85);
      tick();
      tick();
      done_before = done_cnt;
      for (int w = 0; w < 3; w++) drive_window(1'b0, 32'h55);
      tick();
      tick();
      tick();
      vectors++;
      if (oValid !== 1'b0 || oFace_count !== 8'd0 || done_cnt != done_before) begin
         miscompares++;
         $display("[TB] FAIL done_ignore: got valid=%0b count=%0d extra_done=%0d expected 0 0 0", oValid, oFace_count, done_cnt - done_before);
      end
      pop_head();
      vectors++;
      if (oValid !== 1'b0 || oFace_count !== 8'd0 || oOverflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL idle_ack: got valid=%0b count=%0d ovf=%0b expected 0 0 0", oValid, oFace_count, oOverflow);
      end
   endtask

   task automatic test_reset_midframe();
      int done_before;
      start_frame();
      for (int w = 0; w < 11; w++) drive_window(w > 2, 32'h30 + 32'(w));
      tick();
      tick();
      vectors++;
      if (oValid !== 1'b1 || oFace_count !== 8'd3) begin
         miscompares++;
         $display("[TB] FAIL rst_pre: got valid=%0b count=%0d expected 1 3", oValid, oFace_count);
      end
      done_before = done_cnt;
      drive_window(1'b1, 32'h0);
      #2 iReset_n = 1'b0;
      #1;
      vectors++;
      if (oValid !== 1'b0 || oFace_count !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL rst_immediate: got valid=%0b count=%0d expected 0 0", oValid, oFace_count);
      end
      tick();
      tick();
      iReset_n = 1'b1;
      tick();
      tick();
      vectors++;
      if (done_cnt != done_before || oFrame_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rst_no_done: got %0d pulses, done=%0b expected 0 0", done_cnt - done_before, oFrame_done);
      end
      for (int w = 0; w < 3; w++) drive_window(1'b0, 32'h77);
      tick();
      tick();
      vectors++;
      if (oValid !== 1'b0 || oFace_count !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL idle_ignore: got valid=%0b count=%0d expected 0 0", oValid, oFace_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_overflow();
      test_full_with_ack();
      test_coincident_start();
      test_ignored_after_done();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
